sa_ram_rd_ctrl: RTL and testbench
=================================

SA_RAM_RD_CTRL -- requirements
Module: sa_ram_rd_ctrl

Interface
REQ-001 Parameter: none; geometry fixed by package constants (depth 128, width 256).
REQ-002 nvdla_core_clk  in  1  single clock; all state on its rising edge.
REQ-003 nvdla_core_rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 cmd_pvld  in  1  burst request valid.
REQ-005 cmd_prdy  out  1  burst request accepted when cmd_pvld&cmd_prdy.
REQ-006 cmd_addr  in  7  first word address.
REQ-007 cmd_len  in  7  beats minus one (1..128 beats).
REQ-008 ram_ra  out  7  RAM read address.
REQ-009 ram_re  out  1  RAM read enable; RAM registers ram_ra on it, ram_dout valid next cycle and held until next ram_re.
REQ-010 ram_dout  in  256  RAM read data.
REQ-011 dat_pvld / dat_prdy  out / in  1 / 1  output beat handshake.
REQ-012 dat_pd  out  256  output beat data.
REQ-013 dat_last  out  1  marks final beat of a burst.

Function
REQ-014 FSM states IDLE, BURST; IDLE: cmd_prdy=1; handshake latches addr/len, goes BURST.
REQ-015 BURST: cmd_prdy=0; ram_re asserted when credit available (REQ-018), ram_ra = current address.
REQ-016 Each issued read increments address modulo 128 (0x7F wraps to 0x00) and decrements remaining count; issuing the last beat returns FSM to IDLE the next cycle.
REQ-017 Each read data word is captured into a 2-entry output FIFO (skid) the cycle after its ram_re, together with its last flag.
REQ-018 Credit rule: ram_re only if (fifo occupancy + reads in flight - pop this cycle) < 2; never overflow, never drop data.
REQ-019 With dat_prdy held 1, sustained rate 1 beat/cycle; first dat_pvld 3 cycles after the cmd handshake cycle.
REQ-020 dat_pvld=1 whenever FIFO non-empty; dat_pd/dat_last stable while dat_pvld&!dat_prdy.
REQ-021 Beats emerge in address order; exactly cmd_len+1 beats per burst, dat_last only on final one.
REQ-022 Back-to-back bursts: next command accepted in IDLE cycle after last issue; no bubble required beyond that one cycle.

Reset
REQ-023 During reset: FSM=IDLE, cmd_prdy=0 while rstn low then 1, ram_re=0, ram_ra=0, dat_pvld=0, dat_last=0, dat_pd=0, FIFO empty, in-flight cleared.
REQ-024 Reset mid-burst discards all pending beats; no dat_pvld after release until a new command.

Configuration
REQ-025 SA_RAM_RD_CTRL_PERF_EN defined: add outputs perf_beat_cnt[31:0] (accepted output beats) and perf_stall_cnt[31:0] (cycles dat_pvld&!dat_prdy), both saturating at 0xFFFFFFFF, reset to 0.
REQ-026 Macro undefined: ports and counters absent; functional behaviour identical.

Structure
REQ-027 Package sa_ram_pkg holds SA_RAM_DEPTH=128, SA_RAM_AW=7, SA_RAM_DW=256 and the FSM state encoding.
REQ-028 One sub-module sa_ram_rd_skid: 2-entry FIFO of {last, 256-bit data} with valid/ready out, push in, occupancy out.

Verification
REQ-029 cmd addr=0x10 len=3, dat_prdy=1 -> 4 beats M[0x10..0x13] on consecutive cycles, first 3 cycles after handshake, dat_last on 4th.
REQ-030 cmd addr=0x7E len=3 -> beats M[0x7E],M[0x7F],M[0x00],M[0x01].
REQ-031 len=127 with dat_prdy toggling 1/0 each cycle -> 128 beats in order, dat_pd stable in stalls, ram_re never with credit exhausted.
REQ-032 dat_prdy=0 for 20 cycles during len=7 burst -> at most 2 reads issued before stall, no loss, resumes full rate on release.
REQ-033 Assert rstn low after 2nd beat of len=9 burst -> all outputs reset values, no further beats; new cmd addr=0x40 len=0 -> single beat M[0x40] with dat_last.
REQ-034 PERF_EN build, 5 beats with 3 stall cycles -> perf_beat_cnt=5, perf_stall_cnt=3.

Source files
------------

// File: rtl/sa_ram_pkg.sv
// ============================================================================
// Module      : sa_ram_pkg
// Description : Geometry constants and FSM encoding for the SA RAM read path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sa_ram_pkg;

    localparam int SA_RAM_DEPTH = 128;
    localparam int SA_RAM_AW    = 7;
    localparam int SA_RAM_DW    = 256;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

    // Address increment that wraps at the end of the RAM.
    function automatic logic [SA_RAM_AW-1:0] sa_ram_next_addr(input logic [SA_RAM_AW-1:0] addr);
        return SA_RAM_AW'((int'(addr) + 1) % SA_RAM_DEPTH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sa_ram_rd_skid.sv
// ============================================================================
// Module      : sa_ram_rd_skid
// Description : Two-entry FIFO of {last, data} with valid/ready output side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_ram_rd_skid
    import sa_ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 push_last,
    input  logic [SA_RAM_DW-1:0] push_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [SA_RAM_DW-1:0] out_data,
    output logic                 out_last,
    output logic [1:0]           occupancy
);

    logic [SA_RAM_DW:0] r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_cnt;
    logic               w_pop;

    assign w_pop     = out_vld & out_rdy;
    assign out_vld   = (r_cnt != 2'd0);
    assign out_last  = r_mem[r_rd_ptr][SA_RAM_DW];
    assign out_data  = r_mem[r_rd_ptr][SA_RAM_DW-1:0];
    assign occupancy = r_cnt;

    // The upstream credit check guarantees push never targets a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= {push_last, push_data};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, push} - {1'b0, w_pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/sa_ram_rd_ctrl.sv
// ============================================================================
// Module      : sa_ram_rd_ctrl
// Description : Burst read controller: issues credited RAM reads and streams
//               the words out through a 2-entry skid FIFO.
//               Optional macro SA_RAM_RD_CTRL_PERF_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_ram_rd_ctrl
    import sa_ram_pkg::*;
(
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 cmd_pvld,
    output logic                 cmd_prdy,
    input  logic [SA_RAM_AW-1:0] cmd_addr,
    input  logic [SA_RAM_AW-1:0] cmd_len,
    output logic [SA_RAM_AW-1:0] ram_ra,
    output logic                 ram_re,
    input  logic [SA_RAM_DW-1:0] ram_dout,
    output logic                 dat_pvld,
    input  logic                 dat_prdy,
    output logic [SA_RAM_DW-1:0] dat_pd,
    output logic                 dat_last
`ifdef SA_RAM_RD_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_beat_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    rd_state_e            r_state;
    rd_state_e            w_state_nxt;
    logic [SA_RAM_AW-1:0] r_addr;
    logic [SA_RAM_AW-1:0] r_remain;
    logic                 r_inflight;
    logic                 r_inflight_last;
    logic [1:0]           w_occ;
    logic                 w_pop;
    logic [2:0]           w_commit;
    logic                 w_credit_ok;
    logic                 w_cmd_hs;

    assign w_pop       = dat_pvld & dat_prdy;
    // Words already owed to the FIFO, net of the one leaving this cycle.
    assign w_commit    = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_credit_ok = (w_commit < 3'd2);
    assign w_cmd_hs    = cmd_pvld & cmd_prdy;
    assign ram_ra      = r_addr;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_prdy    = 1'b0;
        ram_re      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_prdy = nvdla_core_rstn;
                if (cmd_pvld && nvdla_core_rstn) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                ram_re = w_credit_ok;
                if (w_credit_ok && (r_remain == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_addr   <= cmd_addr;
                r_remain <= cmd_len;
            end else if (ram_re) begin
                r_addr   <= sa_ram_next_addr(r_addr);
                r_remain <= r_remain - 1'b1;
            end
            r_inflight      <= ram_re;
            r_inflight_last <= ram_re && (r_remain == '0);
        end
    end

    sa_ram_rd_skid u_skid (
        .clk       (nvdla_core_clk),
        .rst_n     (nvdla_core_rstn),
        .push      (r_inflight),
        .push_last (r_inflight_last),
        .push_data (ram_dout),
        .out_vld   (dat_pvld),
        .out_rdy   (dat_prdy),
        .out_data  (dat_pd),
        .out_last  (dat_last),
        .occupancy (w_occ)
    );

`ifdef SA_RAM_RD_CTRL_PERF_EN
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            perf_beat_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_pop && (perf_beat_cnt != 32'hFFFF_FFFF)) begin
                perf_beat_cnt <= perf_beat_cnt + 32'd1;
            end
            if (dat_pvld && !dat_prdy && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sa_ram_rd_ctrl.sv
// ============================================================================
// Module      : tb_sa_ram_rd_ctrl
// Description : Scoreboard bench for sa_ram_rd_ctrl (SA_RAM_RD_CTRL_PERF_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sa_ram_rd_ctrl;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         cmd_pvld = 1'b0;
    logic         cmd_prdy;
    logic [6:0]   cmd_addr = '0;
    logic [6:0]   cmd_len = '0;
    logic [6:0]   ram_ra;
    logic         ram_re;
    logic [255:0] ram_dout = '0;
    logic         dat_pvld;
    logic         dat_prdy = 1'b0;
    logic [255:0] dat_pd;
    logic         dat_last;
`ifdef SA_RAM_RD_CTRL_PERF_EN
    logic [31:0]  perf_beat_cnt;
    logic [31:0]  perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    sa_ram_rd_ctrl dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cmd_pvld        (cmd_pvld),
        .cmd_prdy        (cmd_prdy),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .ram_ra          (ram_ra),
        .ram_re          (ram_re),
        .ram_dout        (ram_dout),
        .dat_pvld        (dat_pvld),
        .dat_prdy        (dat_prdy),
        .dat_pd          (dat_pd),
        .dat_last        (dat_last)
`ifdef SA_RAM_RD_CTRL_PERF_EN
        ,
        .perf_beat_cnt   (perf_beat_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    // RAM model: registered read, output held until the next read.
    logic [255:0] ram [128];
    always @(posedge clk) begin
        if (ram_re === 1'b1) ram_dout <= ram[ram_ra];
    end

    typedef struct packed {
        logic         last;
        logic [255:0] data;
    } beat_t;

    beat_t  exp_q[$];
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    longint hs_cyc = 0;
    longint first_pop_cyc = 0;
    longint last_pop_cyc = 0;
    int     issued = 0;
    int     popped = 0;
    int     pop_cnt = 0;
    logic   prev_stall = 1'b0;
    logic [255:0] prev_pd = '0;
    logic   prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pops, hold-during-stall and credit checks.
    always @(negedge clk) begin
        beat_t e;
        if (!rstn) begin
            issued     = 0;
            popped     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (dat_pvld !== 1'b1 || dat_pd !== prev_pd || dat_last !== prev_last) begin
                    bad++;
                    $display("FAIL stall_hold: got vld=%b last=%b pd=%h want vld=1 last=%b pd=%h",
                             dat_pvld, dat_last, dat_pd, prev_last, prev_pd);
                end
            end
            if (ram_re === 1'b1) begin
                total++;
                if (issued - popped - ((dat_pvld === 1'b1 && dat_prdy === 1'b1) ? 1 : 0) >= 2) begin
                    bad++;
                    $display("FAIL credit: read issued with %0d words owed, want < 2",
                             issued - popped);
                end
                issued++;
            end
            if (dat_pvld === 1'b1 && dat_prdy === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got last=%b pd=%h want no beat", dat_last, dat_pd);
                end else begin
                    e = exp_q.pop_front();
                    if ({dat_last, dat_pd} !== e) begin
                        bad++;
                        $display("FAIL beat: got last=%b pd=%h want last=%b pd=%h",
                                 dat_last, dat_pd, e.last, e.data);
                    end
                end
                if (pop_cnt == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_cnt++;
                popped++;
            end
            prev_stall = (dat_pvld === 1'b1) && (dat_prdy !== 1'b1);
            prev_pd    = dat_pd;
            prev_last  = dat_last;
        end
    end

    // All tasks start and end at posedge+1.
    task automatic send_cmd(input logic [6:0] addr, input logic [6:0] len);
        bit ok = 0;
        for (int i = 0; i <= int'(len); i++) begin
            logic [6:0] a = addr + 7'(i);
            exp_q.push_back({(i == int'(len)), ram[a]});
        end
        cmd_addr = addr;
        cmd_len  = len;
        cmd_pvld = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_prdy === 1'b1) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cmd_accept: got no cmd_prdy within 200 cycles, want handshake");
        end
        hs_cyc = cyc;
        @(posedge clk); #1;
        cmd_pvld = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        bit ok = 0;
        for (int k = 0; k < max_cycles; k++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_drain: got %0d beats outstanding, want 0", name, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 6;
        if (cmd_prdy !== 1'b0) begin bad++; $display("FAIL rst_cmd_prdy: got %b want 0", cmd_prdy); end
        if (ram_re !== 1'b0)   begin bad++; $display("FAIL rst_ram_re: got %b want 0", ram_re); end
        if (ram_ra !== 7'h00)  begin bad++; $display("FAIL rst_ram_ra: got %h want 00", ram_ra); end
        if (dat_pvld !== 1'b0) begin bad++; $display("FAIL rst_dat_pvld: got %b want 0", dat_pvld); end
        if (dat_last !== 1'b0) begin bad++; $display("FAIL rst_dat_last: got %b want 0", dat_last); end
        if (dat_pd !== '0)     begin bad++; $display("FAIL rst_dat_pd: got %h want 0", dat_pd); end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_prdy !== 1'b1) begin bad++; $display("FAIL idle_cmd_prdy: got %b want 1", cmd_prdy); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        dat_prdy = 1'b1;
        pop_cnt  = 0;
        send_cmd(7'h10, 7'd3);
        wait_drain(30, "basic");
        total += 3;
        if (first_pop_cyc - hs_cyc != 3) begin
            bad++; $display("FAIL basic_latency: got %0d want 3", first_pop_cyc - hs_cyc);
        end
        if (last_pop_cyc - first_pop_cyc != 3) begin
            bad++; $display("FAIL basic_rate: got span %0d want 3", last_pop_cyc - first_pop_cyc);
        end
        if (pop_cnt != 4) begin bad++; $display("FAIL basic_count: got %0d want 4", pop_cnt); end
    endtask

    task automatic test_wrap;
        dat_prdy = 1'b1;
        pop_cnt  = 0;
        send_cmd(7'h7E, 7'd3);
        wait_drain(30, "wrap");
        total++;
        if (pop_cnt != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", pop_cnt); end
    endtask

    task automatic test_toggle;
        dat_prdy = 1'b1;
        pop_cnt  = 0;
        send_cmd(7'h05, 7'd127);
        for (int k = 0; k < 600; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
            dat_prdy = ~dat_prdy;
        end
        dat_prdy = 1'b1;
        wait_drain(10, "toggle");
        total++;
        if (pop_cnt != 128) begin bad++; $display("FAIL toggle_count: got %0d want 128", pop_cnt); end
    endtask

    task automatic test_stall;
        int     iss0;
        longint rel_cyc;
        dat_prdy = 1'b0;
        pop_cnt  = 0;
        iss0     = issued;
        send_cmd(7'h20, 7'd7);
        repeat (20) @(posedge clk);
        #1;
        total += 3;
        if (issued - iss0 != 2) begin bad++; $display("FAIL stall_reads: got %0d want 2", issued - iss0); end
        if (pop_cnt != 0) begin bad++; $display("FAIL stall_pops: got %0d want 0", pop_cnt); end
        if (dat_pvld !== 1'b1) begin bad++; $display("FAIL stall_pvld: got %b want 1", dat_pvld); end
        dat_prdy = 1'b1;
        rel_cyc  = cyc;
        wait_drain(30, "stall");
        total += 3;
        if (first_pop_cyc != rel_cyc) begin
            bad++; $display("FAIL stall_resume: got %0d want %0d", first_pop_cyc, rel_cyc);
        end
        if (last_pop_cyc != rel_cyc + 7) begin
            bad++; $display("FAIL stall_rate: got %0d want %0d", last_pop_cyc, rel_cyc + 7);
        end
        if (pop_cnt != 8) begin bad++; $display("FAIL stall_count: got %0d want 8", pop_cnt); end
    endtask

    task automatic test_back_to_back;
        longint h1;
        dat_prdy = 1'b1;
        pop_cnt  = 0;
        send_cmd(7'h30, 7'd3);
        h1 = hs_cyc;
        send_cmd(7'h50, 7'd1);
        wait_drain(30, "b2b");
        total += 3;
        if (hs_cyc - h1 != 5) begin bad++; $display("FAIL b2b_accept: got %0d want 5", hs_cyc - h1); end
        if (last_pop_cyc - h1 != 9) begin bad++; $display("FAIL b2b_end: got %0d want 9", last_pop_cyc - h1); end
        if (pop_cnt != 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", pop_cnt); end
    endtask

    task automatic test_reset_mid;
        dat_prdy = 1'b1;
        pop_cnt  = 0;
        send_cmd(7'h38, 7'd9);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            if (pop_cnt >= 2) break;
        end
        rstn = 1'b0;
        #1;
        exp_q.delete();
        total += 6;
        if (dat_pvld !== 1'b0) begin bad++; $display("FAIL mid_dat_pvld: got %b want 0", dat_pvld); end
        if (ram_re !== 1'b0)   begin bad++; $display("FAIL mid_ram_re: got %b want 0", ram_re); end
        if (cmd_prdy !== 1'b0) begin bad++; $display("FAIL mid_cmd_prdy: got %b want 0", cmd_prdy); end
        if (dat_last !== 1'b0) begin bad++; $display("FAIL mid_dat_last: got %b want 0", dat_last); end
        if (dat_pd !== '0)     begin bad++; $display("FAIL mid_dat_pd: got %h want 0", dat_pd); end
        if (ram_ra !== 7'h00)  begin bad++; $display("FAIL mid_ram_ra: got %h want 00", ram_ra); end
        repeat (2) @(posedge clk);
        #1;
        rstn    = 1'b1;
        pop_cnt = 0;
        repeat (15) @(posedge clk);
        #1;
        total += 2;
        if (pop_cnt != 0) begin bad++; $display("FAIL mid_no_beats: got %0d want 0", pop_cnt); end
        if (dat_pvld !== 1'b0) begin bad++; $display("FAIL mid_idle_pvld: got %b want 0", dat_pvld); end
        send_cmd(7'h40, 7'd0);
        wait_drain(20, "single");
        total++;
        if (pop_cnt != 1) begin bad++; $display("FAIL single_count: got %0d want 1", pop_cnt); end
    endtask

    task automatic test_perf;
        bit ok = 0;
`ifdef SA_RAM_RD_CTRL_PERF_EN
        logic [31:0] b0 = perf_beat_cnt;
        logic [31:0] s0 = perf_stall_cnt;
`endif
        dat_prdy = 1'b0;
        pop_cnt  = 0;
        send_cmd(7'h60, 7'd4);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dat_pvld === 1'b1) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL perf_first: got no dat_pvld, want beat"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dat_prdy = 1'b1;
        wait_drain(30, "perf");
        total++;
        if (pop_cnt != 5) begin bad++; $display("FAIL perf_count: got %0d want 5", pop_cnt); end
`ifdef SA_RAM_RD_CTRL_PERF_EN
        total += 2;
        if (perf_beat_cnt - b0 != 32'd5) begin
            bad++; $display("FAIL perf_beat_cnt: got %0d want 5", perf_beat_cnt - b0);
        end
        if (perf_stall_cnt - s0 != 32'd3) begin
            bad++; $display("FAIL perf_stall_cnt: got %0d want 3", perf_stall_cnt - s0);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), 32'(i)};
        end
        test_reset();
        test_basic();
        test_wrap();
        test_toggle();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_perf();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL final_queue: got %0d outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
